// File: rtl/seq_dot_pkg.sv
// Shared types and sizing helpers for the sequential digit-serial dot-product accumulator.
package seq_dot_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Number of P-bit digits in a full-width operand.
  function automatic int calc_nd(input int max_width, input int p);
    return max_width / p;
  endfunction

  // Accumulator width: full product, growth over K lanes, plus one guard bit.
  function automatic int calc_acc_w(input int max_width, input int k);
    return 2 * max_width + $clog2(k) + 1;
  endfunction

endpackage

// File: rtl/seq_dot_accum_digit_pp.sv
// Combinational sum of K lane products of one P-bit digit pair, each digit
// optionally treated as a two's-complement top digit.
module digit_pp #(
  parameter int K     = 4,
  parameter int P     = 2,
  parameter int OUT_W = 35
) (
  input  logic [K-1:0][P-1:0]  a_dig_i,
  input  logic [K-1:0][P-1:0]  b_dig_i,
  input  logic                 a_sgn_i,
  input  logic                 b_sgn_i,
  output logic signed [OUT_W-1:0] sum_o
);

  logic signed [P:0]     ae;
  logic signed [P:0]     be;
  logic signed [2*P+1:0] prod;

  // Extend each digit by one bit (sign or zero), multiply, and sum across lanes.
  always_comb begin
    sum_o = '0;
    ae    = '0;
    be    = '0;
    prod  = '0;
    for (int k = 0; k < K; k++) begin
      ae    = a_sgn_i ? $signed({a_dig_i[k][P-1], a_dig_i[k]}) : $signed({1'b0, a_dig_i[k]});
      be    = b_sgn_i ? $signed({b_dig_i[k][P-1], b_dig_i[k]}) : $signed({1'b0, b_dig_i[k]});
      prod  = ae * be;
      sum_o = sum_o + OUT_W'(prod);
    end
  end

endmodule

// File: rtl/seq_dot_accum.sv
// Digit-serial K-lane dot product with addend: D = addend + sum A[k]*B[k],
// one digit-pair term per cycle, handshaked in and out.
module seq_dot_accum
  import seq_dot_pkg::*;
#(
  parameter  int K         = 4,
  parameter  int P         = 2,
  parameter  int MAX_WIDTH = 16,
  localparam int ND        = calc_nd(MAX_WIDTH, P),
  localparam int ACC_W     = calc_acc_w(MAX_WIDTH, K)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [K-1:0][MAX_WIDTH-1:0]   A_i,
  input  logic [K-1:0][MAX_WIDTH-1:0]   B_i,
  input  logic signed [ACC_W-1:0]       C_i,
  input  logic [4:0]                    bitSizeA,
  input  logic [4:0]                    bitSizeB,
  input  logic                          signed_a,
  input  logic                          signed_b,
  input  logic                          acc_en,
  input  logic                          valid_in,
  output logic                          ready_in,
  output logic signed [ACC_W-1:0]       D_o,
  output logic                          valid_out,
  input  logic                          ready_out
);

  localparam int CNT_W = $clog2(ND + 1);

  // Active digit count limited to 1..ND; zero width is treated as one digit.
  function automatic logic [CNT_W-1:0] clamp_digits(input logic [4:0] v);
    if (v == 5'd0)        return CNT_W'(1);
    else if (int'(v) > ND) return CNT_W'(ND);
    else                  return CNT_W'(v);
  endfunction

  state_e                        state_q, state_d;
  logic [K-1:0][MAX_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0]              na_q, na_d, nb_q, nb_d;
  logic [CNT_W-1:0]              i_q, i_d, j_q, j_d;
  logic                          sa_q, sa_d, sb_q, sb_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d, d_q, d_d;
  logic                          valid_q, valid_d;

  logic [K-1:0][P-1:0]           a_dig, b_dig;
  logic                          a_top, b_top;
  logic signed [ACC_W-1:0]       pp, term;

  // Select the current digit pair; only the top digit of a signed operand carries sign.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int k = 0; k < K; k++) begin
      a_dig[k] = a_q[k][i_q*P +: P];
      b_dig[k] = b_q[k][j_q*P +: P];
    end
    a_top = sa_q && (i_q == na_q - 1'b1);
    b_top = sb_q && (j_q == nb_q - 1'b1);
    term  = pp <<< (P * (int'(i_q) + int'(j_q)));
  end

  digit_pp #(
    .K     (K),
    .P     (P),
    .OUT_W (ACC_W)
  ) u_digit_pp (
    .a_dig_i (a_dig),
    .b_dig_i (b_dig),
    .a_sgn_i (a_top),
    .b_sgn_i (b_top),
    .sum_o   (pp)
  );

  // Next-state logic: accept in IDLE, walk j inner / i outer in COMPUTE, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    na_d    = na_q;
    nb_d    = nb_q;
    i_d     = i_q;
    j_d     = j_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    d_d     = d_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          a_d     = A_i;
          b_d     = B_i;
          na_d    = clamp_digits(bitSizeA);
          nb_d    = clamp_digits(bitSizeB);
          sa_d    = signed_a;
          sb_d    = signed_b;
          acc_d   = acc_en ? d_q : C_i;
          i_d     = '0;
          j_d     = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        acc_d = acc_q + term;
        if (j_q == nb_q - 1'b1) begin
          j_d = '0;
          if (i_q == na_q - 1'b1) begin
            i_d     = '0;
            d_d     = acc_q + term;
            valid_d = 1'b1;
            state_d = DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DONE: begin
        if (ready_out) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, accumulator and result register; operand captures are not reset.
  always_ff @(posedge clk_i) begin
    a_q  <= a_d;
    b_q  <= b_d;
    na_q <= na_d;
    nb_q <= nb_d;
    sa_q <= sa_d;
    sb_q <= sb_d;
    if (!rst_ni) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      d_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      d_q     <= d_d;
      valid_q <= valid_d;
    end
  end

  assign ready_in  = (state_q == IDLE);
  assign valid_out = valid_q;
  assign D_o       = d_q;

endmodule

// File: tb/tb_seq_dot_accum.sv
// Directed vector bench for seq_dot_accum with K=2, P=2, MAX_WIDTH=16.
module tb_seq_dot_accum;

  localparam int K     = 2;
  localparam int P     = 2;
  localparam int MW    = 16;
  localparam int ACC_W = 34;

  logic                     clk = 1'b0;
  logic                     rst_ni;
  logic [K-1:0][MW-1:0]     A_i, B_i;
  logic signed [ACC_W-1:0]  C_i;
  logic [4:0]               bitSizeA, bitSizeB;
  logic                     signed_a, signed_b, acc_en;
  logic                     valid_in, ready_in, valid_out, ready_out;
  logic signed [ACC_W-1:0]  D_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_dot_accum #(.K(K), .P(P), .MAX_WIDTH(MW)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .A_i       (A_i),
    .B_i       (B_i),
    .C_i       (C_i),
    .bitSizeA  (bitSizeA),
    .bitSizeB  (bitSizeB),
    .signed_a  (signed_a),
    .signed_b  (signed_b),
    .acc_en    (acc_en),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .D_o       (D_o),
    .valid_out (valid_out),
    .ready_out (ready_out)
  );

  typedef struct {
    logic [MW-1:0]           a0, a1, b0, b1;
    logic signed [ACC_W-1:0] c;
    logic [4:0]              bsa, bsb;
    logic                    sa, sb, acc;
    logic signed [ACC_W-1:0] exp_d;
    int                      exp_lat;
    string                   name;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    A_i[0]   = v.a0;
    A_i[1]   = v.a1;
    B_i[0]   = v.b0;
    B_i[1]   = v.b1;
    C_i      = v.c;
    bitSizeA = v.bsa;
    bitSizeB = v.bsb;
    signed_a = v.sa;
    signed_b = v.sb;
    acc_en   = v.acc;
    valid_in = 1'b1;
  endtask

  task automatic start_txn(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (valid_out !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int pulses;

    vecs[0] = '{16'hFFFD, 16'd5,  16'd7,    16'hFFFE, 34'sd10,  5'd2,  5'd2, 1'b1, 1'b1, 1'b0, -34'sd21,        4,  "signed_small"};
    vecs[1] = '{16'h8000, 16'd0,  16'h8000, 16'd0,    34'sd0,   5'd8,  5'd8, 1'b1, 1'b1, 1'b0, 34'sd1073741824, 64, "signed_full_min"};
    vecs[2] = '{16'd255,  16'd255, 16'd255, 16'd1,    34'sd0,   5'd4,  5'd4, 1'b0, 1'b0, 1'b0, 34'sd65280,      16, "unsigned_255"};
    vecs[3] = '{16'h00FF, 16'd0,  16'd1,    16'd0,    34'sd0,   5'd2,  5'd2, 1'b1, 1'b1, 1'b0, -34'sd1,         4,  "upper_bits_ignored"};
    vecs[4] = '{16'd1,    16'd2,  16'd3,    16'd4,    34'sd100, 5'd2,  5'd2, 1'b0, 1'b0, 1'b0, 34'sd111,        4,  "addend_c"};
    vecs[5] = '{16'd1,    16'd2,  16'd3,    16'd4,    34'sd999, 5'd2,  5'd2, 1'b0, 1'b0, 1'b1, 34'sd122,        4,  "accumulate_d"};
    vecs[6] = '{16'd6,    16'd3,  16'd1,    16'd1,    34'sd0,   5'd0,  5'd1, 1'b0, 1'b0, 1'b0, 34'sd5,          1,  "bitsize_zero"};
    vecs[7] = '{16'h1234, 16'd0,  16'd1,    16'd0,    34'sd0,   5'd31, 5'd1, 1'b0, 1'b0, 1'b0, 34'sd4660,       8,  "bitsize_clamp"};
    vecs[8] = '{16'd3,    16'd0,  16'hFFFF, 16'd0,    -34'sd5,  5'd1,  5'd1, 1'b0, 1'b1, 1'b0, -34'sd8,         1,  "mixed_sign"};

    rst_ni    = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b0;
    A_i       = '0;
    B_i       = '0;
    C_i       = '0;
    bitSizeA  = 5'd0;
    bitSizeB  = 5'd0;
    signed_a  = 1'b0;
    signed_b  = 1'b0;
    acc_en    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset ready_in", ready_in, 1);
    chk("reset valid_out", valid_out, 0);
    chk("reset D_o", D_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Table of directed transactions with immediate output acceptance.
    ready_out = 1'b1;
    for (int i = 0; i < 9; i++) begin
      start_txn(vecs[i]);
      chk({vecs[i].name, " busy ready_in"}, ready_in, 0);
      wait_valid(lat);
      chk({vecs[i].name, " latency"}, lat, vecs[i].exp_lat);
      chk({vecs[i].name, " D_o"}, D_o, vecs[i].exp_d);
      @(posedge clk);
      #1;
      chk({vecs[i].name, " ready_in after"}, ready_in, 1);
      chk({vecs[i].name, " valid_out after"}, valid_out, 0);
    end

    // Output backpressure: result held, new requests ignored.
    ready_out = 1'b0;
    start_txn(vecs[0]);
    wait_valid(lat);
    chk("bp latency", lat, 4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      A_i[0]   = 16'd7;
      C_i      = 34'sd500;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      chk("bp valid_out held", valid_out, 1);
      chk("bp D_o stable", D_o, -21);
      chk("bp ready_in low", ready_in, 0);
    end
    @(negedge clk);
    valid_in  = 1'b0;
    ready_out = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release ready_in", ready_in, 1);
    chk("bp release valid_out", valid_out, 0);
    chk("bp release D_o", D_o, -21);

    // Reset in the middle of COMPUTE aborts without a result pulse.
    start_txn(vecs[1]);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    chk("rst compute valid_out", valid_out, 0);
    chk("rst compute D_o", D_o, 0);
    chk("rst compute ready_in", ready_in, 1);
    @(negedge clk);
    rst_ni = 1'b1;
    pulses = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (valid_out === 1'b1) pulses++;
    end
    chk("rst compute no pulse", pulses, 0);
    chk("rst compute idle", ready_in, 1);

    // Reset while holding a result in DONE.
    ready_out = 1'b0;
    start_txn(vecs[2]);
    wait_valid(lat);
    chk("done hold D_o", D_o, 65280);
    @(negedge clk);
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    chk("rst done valid_out", valid_out, 0);
    chk("rst done D_o", D_o, 0);
    chk("rst done ready_in", ready_in, 1);
    @(negedge clk);
    rst_ni    = 1'b1;
    ready_out = 1'b1;

    // Accumulate from the cleared result after reset: 0 + 3 + 8.
    start_txn(vecs[5]);
    wait_valid(lat);
    chk("post reset accumulate latency", lat, 4);
    chk("post reset accumulate D_o", D_o, 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
